// File: rtl/mini_mips_control.sv
// rtl/mini_mips_control.sv - multi-cycle control FSM for the 16-bit mini MIPS datapath
// Optional retired-instruction counter: define MINI_MIPS_RETIRE_COUNT_EN.
module mini_mips_control (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  opcode,
  input  logic [2:0]  func,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        ir_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        iord,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_op,
  output logic        busy,
  output logic        halted,
  output logic        illegal
`ifdef MINI_MIPS_RETIRE_COUNT_EN
  ,
  output logic [15:0] retired
`endif
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6,
    ERR    = 3'd7
  } state_t;

  localparam logic [3:0] OP_R    = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_ANDI = 4'h2;
  localparam logic [3:0] OP_ORI  = 4'h3;
  localparam logic [3:0] OP_LW   = 4'h4;
  localparam logic [3:0] OP_SW   = 4'h5;
  localparam logic [3:0] OP_BEQ  = 4'h6;
  localparam logic [3:0] OP_BNE  = 4'h7;
  localparam logic [3:0] OP_J    = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  state_t state, state_nx;
  logic   op_legal;

  always_comb begin
    case (opcode)
      OP_R:    op_legal = (func != 3'b111);
      OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW,
      OP_BEQ, OP_BNE, OP_J, OP_HALT: op_legal = 1'b1;
      default: op_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = ALU_ADD;
    halted     = 1'b0;
    illegal    = 1'b0;
    busy       = !(state inside {IDLE, HALT, ERR});

    case (state)
      IDLE: if (start) state_nx = FETCH;

      FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          alu_src_b = 2'b01;
          state_nx  = DECODE;
        end
      end

      // ALU precomputes pc + offset so a branch finds its target in ALUOut
      DECODE: begin
        alu_src_b = 2'b11;
        if (!op_legal) begin
          state_nx = ERR;
        end else if (opcode == OP_J) begin
          pc_write = 1'b1;
          pc_src   = 2'b10;
          state_nx = FETCH;
        end else if (opcode == OP_HALT) begin
          state_nx = HALT;
        end else begin
          state_nx = EXEC;
        end
      end

      EXEC: begin
        alu_src_a = 1'b1;
        case (opcode)
          OP_R: begin
            alu_op   = func;
            state_nx = WB;
          end
          OP_ADDI, OP_ANDI, OP_ORI: begin
            alu_src_b = 2'b10;
            alu_op    = (opcode == OP_ANDI) ? ALU_AND :
                        (opcode == OP_ORI)  ? ALU_OR  : ALU_ADD;
            state_nx  = WB;
          end
          OP_LW, OP_SW: begin
            alu_src_b = 2'b10;
            state_nx  = MEM;
          end
          OP_BEQ, OP_BNE: begin
            alu_op   = ALU_SUB;
            pc_src   = 2'b01;
            pc_write = (opcode == OP_BEQ) ? zero : !zero;
            state_nx = FETCH;
          end
          default: state_nx = ERR;
        endcase
      end

      MEM: begin
        iord      = 1'b1;
        mem_read  = (opcode == OP_LW);
        mem_write = (opcode == OP_SW);
        if (mem_ready) state_nx = (opcode == OP_LW) ? WB : FETCH;
      end

      WB: begin
        reg_write  = 1'b1;
        reg_dst    = (opcode == OP_R);
        mem_to_reg = (opcode == OP_LW);
        state_nx   = FETCH;
      end

      HALT: halted = 1'b1;

      ERR: illegal = 1'b1;

      default: state_nx = IDLE;
    endcase
  end

`ifdef MINI_MIPS_RETIRE_COUNT_EN
  // Every legal path back to FETCH finishes an instruction; HALT retires the halt itself
  logic retire;

  always_comb begin
    retire = ((state_nx == FETCH) && (state inside {DECODE, EXEC, MEM, WB})) ||
             ((state == DECODE) && (state_nx == HALT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      retired <= 16'd0;
    else if (retire) retired <= retired + 16'd1;
  end
`endif

endmodule

// File: tb/tb_mini_mips_control.sv
// tb/tb_mini_mips_control.sv - randomized trace-based bench for mini_mips_control
// Retired counter is checked too when MINI_MIPS_RETIRE_COUNT_EN is defined.
module tb_mini_mips_control;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       busy;
    logic       halted;
    logic       illegal;
  } ctl_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic [2:0] func = 3'h0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, ir_write, mem_read, mem_write, iord, reg_write;
  logic       reg_dst, mem_to_reg, alu_src_a, busy, halted, illegal;
  logic [1:0] pc_src, alu_src_b;
  logic [2:0] alu_op;
`ifdef MINI_MIPS_RETIRE_COUNT_EN
  logic [15:0] retired;
`endif

  ctl_t outs;
  assign outs = {pc_write, pc_src, ir_write, mem_read, mem_write, iord, reg_write,
                 reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, busy, halted, illegal};

  mini_mips_control dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .func(func),
    .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .mem_read(mem_read),
    .mem_write(mem_write), .iord(iord), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .busy(busy), .halted(halted), .illegal(illegal)
`ifdef MINI_MIPS_RETIRE_COUNT_EN
    , .retired(retired)
`endif
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          n_instr = 0;
  logic [15:0] ret_exp = 16'd0;
  logic [3:0]  cur_op;
  logic [2:0]  cur_fn;
  logic        cur_z;
  ctl_t        exp_q[$];
  bit          rdy_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic check_retired(input string tag);
`ifdef MINI_MIPS_RETIRE_COUNT_EN
    check({tag, "_retired"}, {16'd0, retired}, {16'd0, ret_exp});
`endif
  endtask

  function automatic bit is_legal(input logic [3:0] op, input logic [2:0] fn);
    return (op inside {[4'h1:4'h8], 4'hF}) || (op == 4'h0 && fn != 3'd7);
  endfunction

  task automatic push(input ctl_t c, input bit r);
    exp_q.push_back(c);
    rdy_q.push_back(r);
  endtask

  // Expected per-cycle control trace of one instruction, from FETCH up to its last cycle
  task automatic plan(input logic [3:0] op, input logic [2:0] fn, input logic z,
                      input int fw, input int mw);
    ctl_t c;
    c = '0; c.busy = 1; c.mem_read = 1;
    repeat (fw) push(c, 1'b0);
    c.ir_write = 1; c.pc_write = 1; c.alu_src_b = 2'b01;
    push(c, 1'b1);
    c = '0; c.busy = 1; c.alu_src_b = 2'b11;
    if (is_legal(op, fn) && op == 4'h8) begin c.pc_write = 1; c.pc_src = 2'b10; end
    push(c, 1'($urandom));
    if (!is_legal(op, fn) || op == 4'h8 || op == 4'hF) return;
    c = '0; c.busy = 1; c.alu_src_a = 1;
    case (op)
      4'h0: c.alu_op = fn;
      4'h1, 4'h4, 4'h5: begin c.alu_src_b = 2'b10; c.alu_op = 3'b000; end
      4'h2: begin c.alu_src_b = 2'b10; c.alu_op = 3'b010; end
      4'h3: begin c.alu_src_b = 2'b10; c.alu_op = 3'b011; end
      default: begin
        c.alu_op = 3'b001; c.pc_src = 2'b01;
        c.pc_write = (op == 4'h6) ? z : !z;
      end
    endcase
    push(c, 1'($urandom));
    if (op == 4'h6 || op == 4'h7) return;
    if (op == 4'h4 || op == 4'h5) begin
      c = '0; c.busy = 1; c.iord = 1;
      c.mem_read = (op == 4'h4); c.mem_write = (op == 4'h5);
      repeat (mw) push(c, 1'b0);
      push(c, 1'b1);
      if (op == 4'h5) return;
    end
    c = '0; c.busy = 1; c.reg_write = 1;
    c.reg_dst = (op == 4'h0); c.mem_to_reg = (op == 4'h4);
    push(c, 1'($urandom));
  endtask

  task automatic apply_trace(input int n);
    int   i;
    ctl_t e;
    bit   r;
    i = 0;
    while (exp_q.size() > 0 && (n < 0 || i < n)) begin
      e = exp_q.pop_front();
      r = rdy_q.pop_front();
      @(negedge clk);
      opcode = cur_op; func = cur_fn; zero = cur_z; mem_ready = r;
      start = 1'($urandom);
      #1;
      check($sformatf("i%0d_op%h_f%0d_c%0d", n_instr, cur_op, cur_fn, i), outs, e);
      check_retired($sformatf("i%0d_c%0d", n_instr, i));
      i++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0;
    ret_exp = 16'd0;
    #1 check("reset_outs", outs, '0);
    check_retired("reset");
    @(negedge clk); rst_n = 1'b1;
    #1 check("idle_hold", outs, '0);
    @(negedge clk); start = 1'b1; mem_ready = 1'($urandom);
    #1 check("idle_start", outs, '0);
  endtask

  task automatic hold_terminal(input bit is_halt);
    ctl_t e;
    e = '0; e.halted = is_halt; e.illegal = !is_halt;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      start = (k % 3 == 0) ? 1'b1 : 1'($urandom);
      opcode = 4'($urandom); func = 3'($urandom); mem_ready = 1'($urandom);
      #1 check($sformatf("i%0d_term_%s_c%0d", n_instr, is_halt ? "halt" : "err", k), outs, e);
      check_retired("term");
    end
    do_reset();
  endtask

  task automatic run(input logic [3:0] op, input logic [2:0] fn, input logic z,
                     input int fw, input int mw);
    cur_op = op; cur_fn = fn; cur_z = z;
    plan(op, fn, z, fw, mw);
    apply_trace(-1);
    n_instr++;
    if (!is_legal(op, fn)) begin
      hold_terminal(1'b0);
    end else if (op == 4'hF) begin
      ret_exp = ret_exp + 16'd1;
      hold_terminal(1'b1);
    end else begin
      ret_exp = ret_exp + 16'd1;
    end
  endtask

  initial begin
    logic [3:0] op;
    logic [3:0] legal_ops [10];
    legal_ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hF};
    #2 do_reset();

    run(4'h0, 3'd1, 1'b0, 0, 0);
    run(4'h4, 3'($urandom), 1'b0, 2, 3);
    run(4'h6, 3'd0, 1'b1, 0, 0);
    run(4'h6, 3'd0, 1'b0, 0, 0);
    run(4'h7, 3'd0, 1'b1, 0, 0);
    run(4'h7, 3'd0, 1'b0, 0, 0);
    run(4'hF, 3'd0, 1'b0, 0, 0);
    run(4'h8, 3'd2, 1'b0, 0, 0);
    run(4'h8, 3'd5, 1'b1, 1, 0);
    run(4'h8, 3'd0, 1'b0, 0, 0);
    run(4'hA, 3'd0, 1'b0, 0, 0);
    run(4'h0, 3'd7, 1'b0, 1, 0);

    // sw interrupted by reset while its write request is outstanding
    cur_op = 4'h5; cur_fn = 3'd0; cur_z = 1'b0;
    plan(4'h5, 3'd0, 1'b0, 1, 3);
    apply_trace(5);
    #1 rst_n = 1'b0;
    #1 check("rst_mid_mem", outs, '0);
    exp_q.delete();
    rdy_q.delete();
    do_reset();

    repeat (150) begin
      op = ($urandom_range(0, 3) != 0) ? legal_ops[$urandom_range(0, 9)] : 4'($urandom);
      run(op, 3'($urandom), 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
